// File: rtl/ts_sync_lock_if.sv
// Byte stream in, aligned/framed byte stream out, for one TS channel.
interface ts_sync_lock_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic [7:0] byte_out;
   logic       out_valid;
   logic       sop;
   logic       eop;
   logic       locked;
   logic       sync_err;

   modport master (
      output byte_in, byte_valid,
      input  byte_out, out_valid, sop, eop, locked, sync_err
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_out, out_valid, sop, eop, locked, sync_err
   );
endinterface

// File: rtl/ts_sync_lock.sv
// MPEG-2 TS sync hunt/verify/lock with flywheel; forwards aligned bytes
// with sop/eop strobes once locked.
module ts_sync_lock #(
   parameter int         PKT_LEN    = 188,
   parameter logic [7:0] SYNC_BYTE  = 8'h47,
   parameter int         LOCK_CNT   = 3,
   parameter int         UNLOCK_CNT = 3
) (
   input  logic           clk,
   input  logic           rst,
   ts_sync_lock_if.slave  bus
);

   localparam int             PW       = $clog2(PKT_LEN);
   localparam logic [PW-1:0]  LAST     = PW'(PKT_LEN - 1);
   localparam logic [3:0]     LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0]     UNLOCK_N = 4'(UNLOCK_CNT);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

   state_t        r_state;
   logic [PW-1:0] r_pos;
   logic [3:0]    r_good;
   logic [3:0]    r_miss;
   logic [7:0]    r_byte_out;
   logic          r_out_valid;
   logic          r_sop;
   logic          r_eop;
   logic          r_locked;
   logic          r_sync_err;

   logic          w_is_sync;
   logic          w_at_sync;
   logic [PW-1:0] w_pos_nxt;
   logic [3:0]    w_good_nxt;
   logic [3:0]    w_miss_nxt;

   assign w_is_sync  = (bus.byte_in == SYNC_BYTE);
   assign w_at_sync  = (r_pos == '0);
   assign w_pos_nxt  = (r_pos == LAST) ? '0 : r_pos + 1'b1;
   assign w_good_nxt = r_good + 4'd1;
   assign w_miss_nxt = r_miss + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= HUNT;
         r_pos       <= '0;
         r_good      <= '0;
         r_miss      <= '0;
         r_byte_out  <= '0;
         r_out_valid <= 1'b0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_locked    <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         // Strobes are single-cycle; idle cycles only clear them.
         r_out_valid <= 1'b0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_sync_err  <= 1'b0;
         if (bus.byte_valid) begin
            r_byte_out <= bus.byte_in;
            unique case (r_state)
               HUNT: begin
                  if (w_is_sync) begin
                     r_state <= VERIFY;
                     r_pos   <= PW'(1);
                     r_good  <= 4'd1;
                  end
               end
               VERIFY: begin
                  r_pos <= w_pos_nxt;
                  if (w_at_sync) begin
                     if (w_is_sync) begin
                        r_good <= w_good_nxt;
                        if (w_good_nxt == LOCK_N) begin
                           r_state     <= LOCK;
                           r_locked    <= 1'b1;
                           r_out_valid <= 1'b1;
                           r_sop       <= 1'b1;
                           r_miss      <= '0;
                        end
                     end else begin
                        r_state <= HUNT;
                        r_pos   <= '0;
                        r_good  <= '0;
                     end
                  end
               end
               LOCK: begin
                  r_pos       <= w_pos_nxt;
                  r_out_valid <= 1'b1;
                  r_sop       <= w_at_sync;
                  r_eop       <= (r_pos == LAST);
                  if (w_at_sync && !w_is_sync) begin
                     r_sync_err <= 1'b1;
                     r_miss     <= w_miss_nxt;
                     // Final miss drops lock and swallows the byte.
                     if (w_miss_nxt == UNLOCK_N) begin
                        r_state     <= HUNT;
                        r_pos       <= '0;
                        r_good      <= '0;
                        r_miss      <= '0;
                        r_locked    <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_sop       <= 1'b0;
                     end
                  end else if (w_at_sync) begin
                     r_miss <= '0;
                  end
               end
               default: r_state <= HUNT;
            endcase
         end
      end
   end

   assign bus.byte_out  = r_byte_out;
   assign bus.out_valid = r_out_valid;
   assign bus.sop       = r_sop;
   assign bus.eop       = r_eop;
   assign bus.locked    = r_locked;
   assign bus.sync_err  = r_sync_err;

endmodule

// File: tb/tb_ts_sync_lock.sv
// Randomized TS streams into two instances (188/3/3 and 204/2/1), checked each
// cycle against an index-arithmetic model, plus literal framing/lock checks.
module tb_ts_sync_lock;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ts_sync_lock_if ifa ();
   ts_sync_lock_if ifb ();

   ts_sync_lock u0 (.clk(clk), .rst(rst), .bus(ifa));
   ts_sync_lock #(.PKT_LEN(204), .SYNC_BYTE(8'h47), .LOCK_CNT(2), .UNLOCK_CNT(1))
      u1 (.clk(clk), .rst(rst), .bus(ifb));

   int n_err = 0;
   int n_chk = 0;

   // Model: mode 0 searching, 1 confirming, 2 locked; offsets from anchor index.
   int mP [2] = '{188, 204};
   int mL [2] = '{3, 2};
   int mU [2] = '{3, 1};
   int m_mode [2], m_anchor [2], m_hits [2], m_miss [2], m_n [2];
   logic [12:0] exp_v [2];   // {byte, valid, sop, eop, locked, err}

   task automatic model_reset(input int k);
      m_mode[k] = 0; m_anchor[k] = 0; m_hits[k] = 0; m_miss[k] = 0; m_n[k] = 0;
      exp_v[k] = '0;
   endtask

   task automatic model_step(input int k, input bit v, input logic [7:0] b);
      int off;
      bit val, sp, ep, er;
      if (!v) begin
         exp_v[k] = {exp_v[k][12:5], 3'b000, exp_v[k][1], 1'b0};
         return;
      end
      off = (m_n[k] - m_anchor[k]) % mP[k];
      val = 0; sp = 0; ep = 0; er = 0;
      case (m_mode[k])
         0: if (b == 8'h47) begin m_mode[k] = 1; m_anchor[k] = m_n[k]; m_hits[k] = 1; end
         1: if (off == 0) begin
               if (b == 8'h47) begin
                  m_hits[k]++;
                  if (m_hits[k] == mL[k]) begin m_mode[k] = 2; m_miss[k] = 0; val = 1; sp = 1; end
               end else m_mode[k] = 0;
            end
         default: begin
            val = 1; sp = (off == 0); ep = (off == mP[k] - 1);
            if (off == 0) begin
               if (b == 8'h47) m_miss[k] = 0;
               else begin
                  er = 1; m_miss[k]++;
                  if (m_miss[k] == mU[k]) begin m_mode[k] = 0; val = 0; sp = 0; end
               end
            end
         end
      endcase
      m_n[k]++;
      exp_v[k] = {b, val, sp, ep, (m_mode[k] == 2), er};
   endtask

   task automatic cmp(input int k, input logic [12:0] a);
      n_chk++;
      if (a !== exp_v[k]) begin
         n_err++;
         $display("FAIL cycle_cmp inst%0d t=%0t dut{byte,v,sop,eop,lck,err}=%h model=%h",
                  k, $time, a, exp_v[k]);
      end
   endtask

   always @(negedge clk) begin
      cmp(0, {ifa.byte_out, ifa.out_valid, ifa.sop, ifa.eop, ifa.locked, ifa.sync_err});
      cmp(1, {ifb.byte_out, ifb.out_valid, ifb.sop, ifb.eop, ifb.locked, ifb.sync_err});
   end

   task automatic lit(input string nm, input logic a, input logic e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s t=%0t got=%b want=%b", nm, $time, a, e);
      end
   endtask

   function automatic logic [7:0] rnd_ns();
      logic [7:0] r;
      do r = 8'($urandom_range(0, 255)); while (r == 8'h47);
      return r;
   endfunction

   task automatic send(input int k, input logic [7:0] b, input bit v);
      @(negedge clk); #1;
      if (k == 0) begin ifa.byte_in = b; ifa.byte_valid = v; ifb.byte_valid = 1'b0; end
      else        begin ifb.byte_in = b; ifb.byte_valid = v; ifa.byte_valid = 1'b0; end
      if (rst) begin
         model_step(0, (k == 0) && v, b);
         model_step(1, (k == 1) && v, b);
      end
   endtask

   task automatic rest(input int k, input int n);
      repeat (n) send(k, rnd_ns(), 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) send(0, 8'h00, 1'b0);
   endtask

   task automatic after_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] b;
      bit v;
      int j;
      model_reset(0); model_reset(1);
      ifa.byte_in = '0; ifa.byte_valid = 1'b0;
      ifb.byte_in = '0; ifb.byte_valid = 1'b0;
      #1 rst = 1'b0;
      idle(3);
      lit("reset_locked", ifa.locked, 1'b0);
      lit("reset_valid", ifa.out_valid, 1'b0);
      @(negedge clk); #1 rst = 1'b1;
      idle(2);

      // Clean 188-byte stream: lock at index 376, eop at 563.
      for (int i = 0; i < 188 * 5; i++) begin
         send(0, (i % 188 == 0) ? 8'h47 : rnd_ns(), 1'b1);
         if (i == 375) begin after_edge(); lit("p1_nolock_375", ifa.locked, 1'b0);
                             lit("p1_noval_375", ifa.out_valid, 1'b0); end
         if (i == 376) begin after_edge(); lit("p1_lock_376", ifa.locked, 1'b1);
                             lit("p1_sop_376", ifa.sop & ifa.out_valid, 1'b1); end
         if (i == 563) begin after_edge(); lit("p1_eop_563", ifa.eop & ifa.out_valid, 1'b1); end
      end

      // Flywheel: one miss tolerated, cleared by a good sync, then three misses drop lock.
      send(0, 8'h00, 1'b1); after_edge();
      lit("fw_err", ifa.sync_err, 1'b1);
      lit("fw_locked", ifa.locked, 1'b1);
      lit("fw_sop_fwd", ifa.sop & ifa.out_valid, 1'b1);
      rest(0, 187);
      send(0, 8'h47, 1'b1); rest(0, 187);
      send(0, 8'h00, 1'b1); after_edge(); lit("miss1_locked", ifa.locked, 1'b1); rest(0, 187);
      send(0, 8'h00, 1'b1); after_edge(); lit("miss2_locked", ifa.locked, 1'b1); rest(0, 187);
      send(0, 8'h00, 1'b1); after_edge();
      lit("miss3_unlock", ifa.locked, 1'b0);
      lit("miss3_nofwd", ifa.out_valid, 1'b0);
      lit("miss3_err", ifa.sync_err, 1'b1);
      rest(0, 187);

      // False sync at 50, real stream from 300: lock on the sync at 676.
      for (int i = 0; i < 300 + 188 * 3 + 20; i++) begin
         if (i == 50 || (i >= 300 && (i - 300) % 188 == 0)) b = 8'h47;
         else b = rnd_ns();
         send(0, b, 1'b1);
         if (i == 675) begin after_edge(); lit("p2_nolock_675", ifa.locked, 1'b0); end
         if (i == 676) begin after_edge(); lit("p2_lock_676", ifa.locked, 1'b1);
                             lit("p2_sop_676", ifa.sop, 1'b1); end
      end

      // Asynchronous reset mid-packet while forwarding.
      @(negedge clk); #2;
      lit("pre_rst_locked", ifa.locked, 1'b1);
      lit("pre_rst_valid", ifa.out_valid, 1'b1);
      rst = 1'b0; ifa.byte_valid = 1'b0;
      model_reset(0); model_reset(1);
      #1;
      lit("rst_async_locked", ifa.locked, 1'b0);
      lit("rst_async_valid", ifa.out_valid, 1'b0);
      lit("rst_async_sop", ifa.sop, 1'b0);
      idle(3);
      @(negedge clk); #1 rst = 1'b1;
      idle(2);

      // Gapped input: lock after 3 packets' worth of accepted bytes.
      j = 0;
      while (j < 188 * 5) begin
         v = 1'($urandom_range(0, 1));
         b = v ? ((j % 188 == 0) ? 8'h47 : rnd_ns()) : 8'($urandom_range(0, 255));
         send(0, b, v);
         if (v) begin
            if (j == 375) begin after_edge(); lit("p4_nolock_375", ifa.locked, 1'b0); end
            if (j == 376) begin after_edge(); lit("p4_lock_376", ifa.locked, 1'b1);
                                lit("p4_sop_376", ifa.sop, 1'b1); end
            j++;
         end
      end

      // 204-byte, LOCK_CNT=2, UNLOCK_CNT=1 instance.
      for (int i = 0; i < 204 * 3; i++) begin
         send(1, (i % 204 == 0) ? 8'h47 : rnd_ns(), 1'b1);
         if (i == 203) begin after_edge(); lit("p5_nolock_203", ifb.locked, 1'b0); end
         if (i == 204) begin after_edge(); lit("p5_lock_204", ifb.locked, 1'b1); end
         if (i == 407) begin after_edge(); lit("p5_eop_407", ifb.eop & ifb.out_valid, 1'b1); end
      end
      send(1, 8'h00, 1'b1); after_edge();
      lit("p5_nofly_unlock", ifb.locked, 1'b0);
      lit("p5_nofly_err", ifb.sync_err, 1'b1);
      lit("p5_nofly_nofwd", ifb.out_valid, 1'b0);
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
